// File: rtl/int_arbiter_if.sv
// Output bundle of the machine-mode trap sequencer towards csr_reg and cu.
// Carries the CSR write port, the pipeline stall, the PC redirect and the
// external-interrupt acknowledge; the arbiter drives it through the master
// modport, consumers listen through the slave modport. All fields are plain
// levels sampled by the consumer every clock, so there is no handshake.
interface int_arbiter_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  logic               csr_we_o;      // CSR write enable
  logic [11:0]        csr_waddr_o;   // CSR address, zero when no write
  logic [XLEN-1:0]    csr_wdata_o;   // CSR data, zero when no write
  logic               busy_o;        // sequencer busy, stall pipeline
  logic               int_assert_o;  // one-cycle redirect pulse to cu
  logic [XLEN-1:0]    int_addr_o;    // redirect target
  logic [NUM_IRQ-1:0] int_ack_o;     // one-hot ack of the taken external line

  modport master (
    output csr_we_o, csr_waddr_o, csr_wdata_o,
    output busy_o, int_assert_o, int_addr_o, int_ack_o
  );

  modport slave (
    input csr_we_o, csr_waddr_o, csr_wdata_o,
    input busy_o, int_assert_o, int_addr_o, int_ack_o
  );
endinterface

// File: rtl/int_arbiter.sv
// Machine-mode interrupt/exception sequencer: picks ecall/ebreak, timer or the
//   lowest enabled external line (or mret) and writes mepc/mstatus/mcause.
// Latency: trap accepted in cycle 0 -> writes in cycles 2/3/4, redirect in 5;
//   mret -> mstatus write and redirect in cycle 2. No backpressure: busy_o
//   stalls the pipeline, events seen while busy are dropped (levels re-fire).
// Ports: clk/rst_n plain; pc/jump/div/decode/csr snapshots in; CSR write port,
//   busy, redirect and ext ack leave through the int_arbiter_if master modport.
module int_arbiter #(
  parameter int XLEN           = 32,
  parameter int NUM_IRQ        = 4,
  parameter int EXT_CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               ecall_i,
  input  logic               ebreak_i,
  input  logic               mret_i,
  input  logic               jump_flag_i,
  input  logic [XLEN-1:0]    jump_addr_i,
  input  logic               div_req_i,
  input  logic               div_busy_i,
  input  logic [XLEN-1:0]    div_pc_i,
  input  logic               timer_irq_i,
  input  logic [NUM_IRQ-1:0] ext_irq_i,
  input  logic [XLEN-1:0]    csr_mtvec_i,
  input  logic [XLEN-1:0]    csr_mepc_i,
  input  logic [XLEN-1:0]    csr_mstatus_i,
  input  logic [XLEN-1:0]    csr_mie_i,
  int_arbiter_if.master      bus
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_TIMER  = {1'b1, (XLEN-1)'(7)};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MSTATUS,
    S_MCAUSE,
    S_ASSERT,
    S_MRET
  } state_e;

  state_e state_q, state_d;

  // Trap context captured at acceptance.
  logic [XLEN-1:0]    cause_q, cause_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [NUM_IRQ-1:0] ack_lat_q, ack_lat_d;
  logic               async_q, async_d;

  // Registered outputs.
  logic               csr_we_q, csr_we_d;
  logic [11:0]        csr_waddr_q, csr_waddr_d;
  logic [XLEN-1:0]    csr_wdata_q, csr_wdata_d;
  logic               int_assert_q, int_assert_d;
  logic [XLEN-1:0]    int_addr_q, int_addr_d;
  logic [NUM_IRQ-1:0] int_ack_q, int_ack_d;

  // ---------------------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------------------
  logic               sync_ok;
  logic               mie_on;
  logic               timer_ok;
  logic [NUM_IRQ-1:0] ext_en;
  logic [NUM_IRQ-1:0] ext_pend;
  logic [NUM_IRQ-1:0] ext_onehot;
  logic               ext_ok;
  logic [XLEN-2:0]    ext_code;
  logic               evt_accept;
  logic [XLEN-1:0]    async_epc;

  // A sync exception is held off while ex redirects or a divide launches, so
  // the reported mepc never points at an instruction that is being squashed.
  assign sync_ok  = (ecall_i | ebreak_i) & ~jump_flag_i & ~div_req_i;
  assign mie_on   = csr_mstatus_i[3];
  assign timer_ok = mie_on & timer_irq_i & csr_mie_i[7];

  always_comb begin
    ext_en = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ext_en[i] = csr_mie_i[EXT_CAUSE_BASE + i];
    end
  end

  assign ext_pend = ext_irq_i & ext_en & {NUM_IRQ{mie_on}};
  assign ext_ok   = |ext_pend;
  // Isolate the lowest set bit: the lowest index has the highest priority.
  assign ext_onehot = ext_pend & (~ext_pend + NUM_IRQ'(1));

  always_comb begin
    ext_code = '0;
    // Descending scan so the lowest pending index is the one that sticks.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (ext_pend[i]) begin
        ext_code = (XLEN-1)'(EXT_CAUSE_BASE + i);
      end
    end
  end

  // An interrupt resumes at whatever the pipeline would have executed next:
  // a taken jump target, else the in-flight divide, else the current pc.
  always_comb begin
    if (jump_flag_i) begin
      async_epc = jump_addr_i;
    end else if (div_req_i | div_busy_i) begin
      async_epc = div_pc_i;
    end else begin
      async_epc = pc_i;
    end
  end

  // rst_n gates acceptance so busy_o reads 0 for the whole reset window.
  assign evt_accept = rst_n & (state_q == S_IDLE) &
                      (sync_ok | timer_ok | ext_ok | mret_i);

  // ---------------------------------------------------------------------------
  // mstatus rewrite values
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] mstatus_trap;
  logic [XLEN-1:0] mstatus_mret;

  always_comb begin
    mstatus_trap    = csr_mstatus_i;
    mstatus_trap[7] = csr_mstatus_i[3];
    mstatus_trap[3] = 1'b0;
  end

  always_comb begin
    mstatus_mret    = csr_mstatus_i;
    mstatus_mret[3] = csr_mstatus_i[7];
    mstatus_mret[7] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Redirect target
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] trap_addr;

  assign mtvec_base = {csr_mtvec_i[XLEN-1:2], 2'b00};
  // Only mode 01 vectors, and only for interrupts; modes 10/11 act as direct.
  assign trap_addr  = (async_q && (csr_mtvec_i[1:0] == 2'b01))
                    ? mtvec_base + {cause_q[XLEN-3:0], 2'b00}
                    : mtvec_base;

  // ---------------------------------------------------------------------------
  // Next state / next outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    ack_lat_d    = ack_lat_q;
    async_d      = async_q;
    csr_we_d     = 1'b0;
    csr_waddr_d  = '0;
    csr_wdata_d  = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;
    int_ack_d    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (sync_ok) begin
          cause_d   = ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
          epc_d     = pc_i;
          async_d   = 1'b0;
          ack_lat_d = '0;
          state_d   = S_MEPC;
        end else if (timer_ok) begin
          cause_d   = CAUSE_TIMER;
          epc_d     = async_epc;
          async_d   = 1'b1;
          ack_lat_d = '0;
          state_d   = S_MEPC;
        end else if (ext_ok) begin
          cause_d   = {1'b1, ext_code};
          epc_d     = async_epc;
          async_d   = 1'b1;
          ack_lat_d = ext_onehot;
          state_d   = S_MEPC;
        end else if (mret_i) begin
          state_d   = S_MRET;
        end
      end

      S_MEPC: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MEPC;
        csr_wdata_d = epc_q;
        state_d     = S_MSTATUS;
      end

      S_MSTATUS: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MSTATUS;
        csr_wdata_d = mstatus_trap;
        state_d     = S_MCAUSE;
      end

      S_MCAUSE: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MCAUSE;
        csr_wdata_d = cause_q;
        state_d     = S_ASSERT;
      end

      S_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = trap_addr;
        int_ack_d    = ack_lat_q;
        state_d      = S_IDLE;
      end

      S_MRET: begin
        csr_we_d     = 1'b1;
        csr_waddr_d  = CSR_MSTATUS;
        csr_wdata_d  = mstatus_mret;
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc_i;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cause_q      <= '0;
      epc_q        <= '0;
      ack_lat_q    <= '0;
      async_q      <= 1'b0;
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= '0;
      csr_wdata_q  <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
      int_ack_q    <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      ack_lat_q    <= ack_lat_d;
      async_q      <= async_d;
      csr_we_q     <= csr_we_d;
      csr_waddr_q  <= csr_waddr_d;
      csr_wdata_q  <= csr_wdata_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
      int_ack_q    <= int_ack_d;
    end
  end

  // Only MTIE and the external-enable field of mie matter here.
  logic unused_mie;
  assign unused_mie = ^csr_mie_i;

  assign bus.csr_we_o     = csr_we_q;
  assign bus.csr_waddr_o  = csr_waddr_q;
  assign bus.csr_wdata_o  = csr_wdata_q;
  assign bus.busy_o       = (state_q != S_IDLE) | evt_accept;
  assign bus.int_assert_o = int_assert_q;
  assign bus.int_addr_o   = int_addr_q;
  assign bus.int_ack_o    = int_ack_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: expected CSR writes and redirects are queued with
//   their due cycle when an event is driven; a negedge monitor pops and
//   compares every write/redirect the DUT produces.
module tb_int_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic        ecall_i = 1'b0;
  logic        ebreak_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        div_req_i = 1'b0;
  logic        div_busy_i = 1'b0;
  logic [31:0] div_pc_i = '0;
  logic        timer_irq_i = 1'b0;
  logic [3:0]  ext_irq_i = '0;
  logic [31:0] csr_mtvec_i = '0;
  logic [31:0] csr_mepc_i = '0;
  logic [31:0] csr_mstatus_i = '0;
  logic [31:0] csr_mie_i = '0;

  int_arbiter_if #(.XLEN(32), .NUM_IRQ(4)) bus ();

  int_arbiter #(.XLEN(32), .NUM_IRQ(4), .EXT_CAUSE_BASE(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (pc_i),
    .ecall_i      (ecall_i),
    .ebreak_i     (ebreak_i),
    .mret_i       (mret_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .div_req_i    (div_req_i),
    .div_busy_i   (div_busy_i),
    .div_pc_i     (div_pc_i),
    .timer_irq_i  (timer_irq_i),
    .ext_irq_i    (ext_irq_i),
    .csr_mtvec_i  (csr_mtvec_i),
    .csr_mepc_i   (csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i),
    .csr_mie_i    (csr_mie_i),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_asrt;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [3:0]  ack;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input int due);
    exp_t e;
    e.is_asrt = 1'b0; e.waddr = a; e.wdata = d; e.addr = '0; e.ack = '0; e.due = due;
    sb.push_back(e);
  endtask

  task automatic push_as(input logic [31:0] a, input logic [3:0] ack, input int due);
    exp_t e;
    e.is_asrt = 1'b1; e.waddr = '0; e.wdata = '0; e.addr = a; e.ack = ack; e.due = due;
    sb.push_back(e);
  endtask

  // Full trap: mepc, mstatus, mcause writes then the redirect.
  task automatic exp_trap(input int c0, input logic [31:0] epc, input logic [31:0] ms,
                          input logic [31:0] cause, input logic [31:0] addr,
                          input logic [3:0] ack);
    push_wr(12'h341, epc, c0 + 2);
    push_wr(12'h300, ms, c0 + 3);
    push_wr(12'h342, cause, c0 + 4);
    push_as(addr, ack, c0 + 5);
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.csr_we_o) begin
        if (sb.size() != 0 && !sb[0].is_asrt) begin
          mon_e = sb.pop_front();
          chk("wr_addr", bus.csr_waddr_o, mon_e.waddr);
          chk("wr_data", bus.csr_wdata_o, mon_e.wdata);
          chk("wr_cycle", cyc, mon_e.due);
        end else begin
          chk("unexpected_wr", bus.csr_we_o, 1'b0);
        end
      end else begin
        chk("idle_wr_bus", {bus.csr_waddr_o, bus.csr_wdata_o}, '0);
      end
      if (bus.int_assert_o) begin
        if (sb.size() != 0 && sb[0].is_asrt) begin
          mon_e = sb.pop_front();
          chk("redir_addr", bus.int_addr_o, mon_e.addr);
          chk("redir_ack", bus.int_ack_o, mon_e.ack);
          chk("redir_cycle", cyc, mon_e.due);
        end else begin
          chk("unexpected_assert", bus.int_assert_o, 1'b0);
        end
      end else begin
        chk("idle_ack", bus.int_ack_o, '0);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_trig();
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    jump_flag_i = 1'b0; div_req_i = 1'b0; div_busy_i = 1'b0;
    timer_irq_i = 1'b0; ext_irq_i = '0;
  endtask

  // Called in the accept cycle: release triggers and watch busy until IDLE.
  task automatic settle(input int len);
    next_cyc();
    clr_trig();
    for (int k = 1; k <= len; k++) begin
      #1;
      chk("busy_seq", bus.busy_o, (k < len));
      if (k < len) next_cyc();
    end
    repeat (2) next_cyc();
  endtask

  int c0;

  initial begin
    // Reset state
    #3;
    chk("rst_we", bus.csr_we_o, 1'b0);
    chk("rst_waddr", bus.csr_waddr_o, '0);
    chk("rst_wdata", bus.csr_wdata_o, '0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_assert", bus.int_assert_o, 1'b0);
    chk("rst_addr", bus.int_addr_o, '0);
    chk("rst_ack", bus.int_ack_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) next_cyc();

    // ecall, direct mtvec
    csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8; pc_i = 32'h100;
    ecall_i = 1'b1;
    c0 = cyc; #1;
    chk("busy_accept_ecall", bus.busy_o, 1'b1);
    exp_trap(c0, 32'h100, 32'h80, 32'd11, 32'h200, 4'b0000);
    settle(5);

    // ebreak with vectored mtvec: sync traps still go to the base
    next_cyc();
    csr_mtvec_i = 32'h301; csr_mstatus_i = 32'h1808; pc_i = 32'h204;
    ebreak_i = 1'b1;
    c0 = cyc;
    exp_trap(c0, 32'h204, 32'h1880, 32'd3, 32'h300, 4'b0000);
    settle(5);

    // ext lines 1,2 pending and enabled, vectored
    next_cyc();
    csr_mtvec_i = 32'h401; csr_mstatus_i = 32'h8; csr_mie_i = 32'h0006_0000; pc_i = 32'h500;
    ext_irq_i = 4'b0110;
    c0 = cyc;
    exp_trap(c0, 32'h500, 32'h80, 32'h8000_0011, 32'h444, 4'b0010);
    settle(5);

    // timer beats ext[0]
    next_cyc();
    csr_mie_i = 32'h0001_0080; pc_i = 32'h600;
    timer_irq_i = 1'b1; ext_irq_i = 4'b0001;
    c0 = cyc;
    exp_trap(c0, 32'h600, 32'h80, 32'h8000_0007, 32'h41c, 4'b0000);
    settle(5);

    // same sources with global MIE clear: nothing happens
    next_cyc();
    csr_mstatus_i = 32'h80;
    timer_irq_i = 1'b1; ext_irq_i = 4'b0001;
    #1;
    chk("busy_mie_off", bus.busy_o, 1'b0);
    repeat (7) next_cyc();
    clr_trig();

    // timer during a busy divide: epc is the divide's pc
    next_cyc();
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200; csr_mie_i = 32'h80;
    pc_i = 32'h90; div_pc_i = 32'h80;
    div_busy_i = 1'b1; timer_irq_i = 1'b1;
    c0 = cyc;
    exp_trap(c0, 32'h80, 32'h80, 32'h8000_0007, 32'h200, 4'b0000);
    settle(5);

    // ext[2] while ex jumps: epc is the jump target, jump wins over divide
    next_cyc();
    csr_mtvec_i = 32'h201; csr_mie_i = 32'h0004_0000;
    jump_flag_i = 1'b1; jump_addr_i = 32'h700; div_busy_i = 1'b1;
    ext_irq_i = 4'b0100;
    c0 = cyc;
    exp_trap(c0, 32'h700, 32'h80, 32'h8000_0012, 32'h248, 4'b0100);
    settle(5);

    // ext[3] taken past a disabled ext[0]; mtvec mode 11 acts as direct
    next_cyc();
    csr_mtvec_i = 32'h803; csr_mie_i = 32'h0008_0000; csr_mstatus_i = 32'h1888;
    pc_i = 32'h940; ext_irq_i = 4'b1001;
    c0 = cyc;
    exp_trap(c0, 32'h940, 32'h1880, 32'h8000_0013, 32'h800, 4'b1000);
    settle(5);

    // ecall deferred while jump_flag_i is high
    next_cyc();
    csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8; csr_mie_i = '0; pc_i = 32'h120;
    ecall_i = 1'b1; jump_flag_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("busy_deferred", bus.busy_o, 1'b0);
      next_cyc();
    end
    jump_flag_i = 1'b0;
    c0 = cyc; #1;
    chk("busy_undeferred", bus.busy_o, 1'b1);
    exp_trap(c0, 32'h120, 32'h80, 32'd11, 32'h200, 4'b0000);
    settle(5);

    // mret
    next_cyc();
    csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80;
    mret_i = 1'b1;
    c0 = cyc;
    push_wr(12'h300, 32'h88, c0 + 2);
    push_as(32'h104, 4'b0000, c0 + 2);
    settle(2);

    // reset while in MSTATUS: only the mepc write may ever appear
    next_cyc();
    csr_mstatus_i = 32'h8; pc_i = 32'h900;
    ecall_i = 1'b1;
    c0 = cyc;
    push_wr(12'h341, 32'h900, c0 + 2);
    next_cyc();
    clr_trig();
    next_cyc();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", bus.csr_we_o, 1'b0);
    chk("midrst_wdata", bus.csr_wdata_o, '0);
    chk("midrst_busy", bus.busy_o, 1'b0);
    chk("midrst_assert", bus.int_assert_o, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) next_cyc();

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
